proc_seq: RTL

PROC_SEQ -- requirements
Module: proc_seq

---
 rtl/proc_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/proc_seq.sv
// proc_seq: multi-cycle instruction sequencer for a simple load/store core.
//
// Walks each instruction through FETCH, DECODE, EXE, MEM and WB, latches the
// fetched word, and decodes the memory strobes and write-back controls from
// the current stage and the latched opcode. Counts retired instructions.
//
// Build option:
//   PROC_SEQ_SKIP_MEM_EN  when defined, instructions that do not touch memory
//                         go EXE -> WB and skip the MEM stage.
//
// Ports:
//   CLK           clock, rising edge active
//   RST           asynchronous reset, active low
//   INSTRUCTION   word from the memory read port
//   STALL         memory not ready (only honoured in FETCH and MEM)
//   ZERO          ALU zero flag, used in WB for conditional branches
//   STATE         current stage (IDLE=0 FETCH=1 DECODE=2 EXE=3 MEM=4 WB=5)
//   INST_REG      latched current instruction
//   MEM_READ      memory read strobe
//   MEM_WRITE     memory write strobe
//   PC_LOAD       program counter update, one cycle per WB
//   RF_WRITE      register file write enable
//   BRANCH_TAKEN  conditional branch resolved taken
//   INST_DONE     retire pulse, one cycle per WB
//   RETIRED_CNT   retired instruction counter, wraps
//
// state  | meaning
// IDLE   | out of reset, waiting for the first edge
// FETCH  | reading instruction memory, holds while STALL
// DECODE | instruction latched, decoding
// EXE    | execute
// MEM    | data memory access, holds while STALL
// WB     | write-back, PC update and retire

module proc_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] INSTRUCTION,
    input  logic                  STALL,
    input  logic                  ZERO,
    output logic [2:0]            STATE,
    output logic [DATA_WIDTH-1:0] INST_REG,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic                  PC_LOAD,
    output logic                  RF_WRITE,
    output logic                  BRANCH_TAKEN,
    output logic                  INST_DONE,
    output logic [CNT_WIDTH-1:0]  RETIRED_CNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t                state;
    logic [DATA_WIDTH-1:0] inst_reg;
    logic [CNT_WIDTH-1:0]  retired_cnt;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_load;
    logic       is_store;
    logic       writes_rf;

    assign opcode   = inst_reg[DATA_WIDTH-1 -: 6];
    assign funct    = inst_reg[5:0];
    assign is_load  = (opcode == OP_LW) || (opcode == OP_POP);
    assign is_store = (opcode == OP_SW) || (opcode == OP_PUSH);

`ifdef PROC_SEQ_SKIP_MEM_EN
    logic is_mem;
    assign is_mem = is_load || is_store;
`endif

    always_comb begin
        writes_rf = 1'b0;
        case (opcode)
            OP_RTYPE: writes_rf = (funct != FN_JR);
            6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h23, 6'h03, 6'h1c:
                writes_rf = 1'b1;
            default:  writes_rf = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            inst_reg    <= '0;
            retired_cnt <= '0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH: begin
                    if (!STALL) begin
                        inst_reg <= INSTRUCTION;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXE;
`ifdef PROC_SEQ_SKIP_MEM_EN
                S_EXE:    state <= is_mem ? S_MEM : S_WB;
`else
                S_EXE:    state <= S_MEM;
`endif
                S_MEM: begin
                    if (!STALL) state <= S_WB;
                end
                S_WB: begin
                    retired_cnt <= retired_cnt + 1'b1;
                    state       <= S_FETCH;
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Decoded straight from the stage register so strobes line up with STATE.
    assign STATE        = state;
    assign INST_REG     = inst_reg;
    assign RETIRED_CNT  = retired_cnt;
    assign MEM_READ     = (state == S_FETCH) || ((state == S_MEM) && is_load);
    assign MEM_WRITE    = (state == S_MEM) && is_store;
    assign PC_LOAD      = (state == S_WB);
    assign INST_DONE    = (state == S_WB);
    assign RF_WRITE     = (state == S_WB) && writes_rf;
    assign BRANCH_TAKEN = (state == S_WB) &&
                          (((opcode == OP_BEQ) && ZERO) || ((opcode == OP_BNE) && !ZERO));

endmodule
